// File: rtl/motor_pkg.sv
// Shared constants and types for the motor move executor.
package motor_pkg;

  localparam int NUM_MOTORS = 6;
  localparam int POS_W      = 10;
  localparam int MAX_POS    = 999;

  typedef logic [2:0]       motor_idx_t;
  typedef logic [POS_W-1:0] pos_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_MOVE  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/motor_driver_step_timer.sv
// Step period counter: runs 0..STEP_DIV-1 while enabled, cleared on demand.
module step_timer #(
  parameter int STEP_DIV = 1000,
  parameter int PULSE_W  = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic pulse_hi_o,
  output logic period_end_o
);

  localparam int CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign pulse_hi_o   = (cnt_q < CW'(PULSE_W));
  assign period_end_o = (cnt_q == CW'(STEP_DIV - 1));

  // Next count: clear has priority, wrap at the end of each period.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = period_end_o ? '0 : cnt_q + CW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/motor_driver.sv
// Executes one committed absolute move at a time and owns all motor positions.
module motor_driver
  import motor_pkg::*;
#(
  parameter int STEP_DIV = 1000,
  parameter int PULSE_W  = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [2:0]            cmd_motor,
  input  logic [POS_W-1:0]      cmd_value,
  input  logic                  abort,
  output logic [NUM_MOTORS-1:0] step,
  output logic [NUM_MOTORS-1:0] dir,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  input  logic [2:0]            pos_sel,
  output logic [POS_W-1:0]      pos_out
);

  state_t     state_q, state_d;
  motor_idx_t motor_q;
  pos_t       target_q;
  pos_t       pos_q [NUM_MOTORS];
  logic       err_q, err_d;

  logic latch_en, dir_load, pos_upd, timer_clr, timer_en;
  logic pulse_hi, period_end;
  logic cmd_ok;
  pos_t cmd_pos, cur_pos, next_pos;

  // Position lookup by index; out-of-range indices read as zero.
  function automatic pos_t pick_pos(input pos_t arr [NUM_MOTORS], input motor_idx_t idx);
    pos_t r;
    r = '0;
    for (int i = 0; i < NUM_MOTORS; i++) begin
      if (idx == motor_idx_t'(i)) r = arr[i];
    end
    return r;
  endfunction

  step_timer #(
    .STEP_DIV(STEP_DIV),
    .PULSE_W (PULSE_W)
  ) u_timer (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (timer_clr),
    .en_i        (timer_en),
    .pulse_hi_o  (pulse_hi),
    .period_end_o(period_end)
  );

  assign cmd_ok   = (cmd_motor < motor_idx_t'(NUM_MOTORS)) && (cmd_value <= pos_t'(MAX_POS));
  assign cmd_pos  = pick_pos(pos_q, cmd_motor);
  assign cur_pos  = pick_pos(pos_q, motor_q);
  assign pos_out  = pick_pos(pos_q, pos_sel);
  assign next_pos = (target_q > cur_pos) ? cur_pos + pos_t'(1) : cur_pos - pos_t'(1);

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q == S_SETUP) || (state_q == S_MOVE);
  assign done      = (state_q == S_DONE);
  assign err       = err_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state and datapath strobes; abort wins over a coinciding period end.
  always_comb begin
    state_d   = state_q;
    latch_en  = 1'b0;
    dir_load  = 1'b0;
    pos_upd   = 1'b0;
    timer_clr = 1'b0;
    timer_en  = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          if (!cmd_ok) begin
            err_d = 1'b1;
          end else if (cmd_value == cmd_pos) begin
            latch_en = 1'b1;
            state_d  = S_DONE;
          end else begin
            // dir is loaded at accept so it is settled during SETUP.
            latch_en = 1'b1;
            dir_load = 1'b1;
            state_d  = S_SETUP;
          end
        end
      end
      S_SETUP: begin
        timer_clr = 1'b1;
        state_d   = abort ? S_IDLE : S_MOVE;
      end
      S_MOVE: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          timer_en = 1'b1;
          if (period_end) begin
            pos_upd = 1'b1;
            if (next_pos == target_q) state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Latched command and the error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      motor_q  <= '0;
      target_q <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= err_d;
      if (latch_en) begin
        motor_q  <= cmd_motor;
        target_q <= cmd_value;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_MOTORS; gi++) begin : g_motor
      // Per-motor position and direction; only the active motor changes.
      always_ff @(posedge clk) begin
        if (rst) begin
          pos_q[gi] <= '0;
          dir[gi]   <= 1'b0;
        end else begin
          if (dir_load && (cmd_motor == motor_idx_t'(gi))) dir[gi] <= (cmd_value > cmd_pos);
          if (pos_upd && (motor_q == motor_idx_t'(gi)))    pos_q[gi] <= next_pos;
        end
      end
      assign step[gi] = (state_q == S_MOVE) && pulse_hi && (motor_q == motor_idx_t'(gi));
    end
  endgenerate

endmodule

// File: tb/tb_motor_driver.sv
// Randomized self-checking bench for motor_driver with a move-level model.
module tb_motor_driver;

  localparam int SD = 4;
  localparam int PW = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_motor = '0;
  logic [9:0] cmd_value = '0;
  logic       abort = 1'b0;
  logic [5:0] step, dir;
  logic       busy, done, err;
  logic [2:0] pos_sel = '0;
  logic [9:0] pos_out;

  int n_cmp = 0;
  int n_mis = 0;
  int model_pos [6];

  motor_driver #(.STEP_DIV(SD), .PULSE_W(PW)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_motor(cmd_motor), .cmd_value(cmd_value), .abort(abort),
    .step(step), .dir(dir), .busy(busy), .done(done), .err(err),
    .pos_sel(pos_sel), .pos_out(pos_out)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sweep every readback select, including the two out-of-range ones.
  task automatic check_all_pos(input string tag);
    logic [2:0] save;
    save = pos_sel;
    for (int s = 0; s < 8; s++) begin
      pos_sel = 3'(s);
      #1;
      check(tag, 32'(pos_out), (s < 6) ? model_pos[s] : 0);
    end
    pos_sel = save;
  endtask

  // One command: abort_k >= 0 aborts in move cycle abort_k; hold keeps a
  // second command (hm, hv) offered for the whole move.
  task automatic run_move(input int m, input int t, input int abort_k,
                          input bit hold, input int hm, input int hv);
    int  start, n, sgn, w, exp_pos;
    bit  ok;
    w = 0;
    while (!cmd_ready && w < 200) begin
      tick();
      w++;
    end
    check("ready_wait", 32'(cmd_ready), 1);
    ok        = (m < 6) && (t <= 999);
    start     = ok ? model_pos[m] : 0;
    cmd_valid = 1'b1;
    cmd_motor = 3'(m);
    cmd_value = 10'(t);
    pos_sel   = 3'(m);
    tick();
    cmd_valid = hold;
    if (hold) begin
      cmd_motor = 3'(hm);
      cmd_value = 10'(hv);
    end
    if (!ok) begin
      check("err_pulse", 32'(err), 1);
      check("err_ready", 32'(cmd_ready), 1);
      check("err_busy", 32'(busy), 0);
      check_all_pos("err_pos");
      tick();
      check("err_clear", 32'(err), 0);
      $display("txn motor=%0d value=%0d rejected", m, t);
    end else if (t == start) begin
      check("zero_done", 32'(done), 1);
      check("zero_step", 32'(step), 0);
      check("zero_busy", 32'(busy), 0);
      tick();
      check("zero_done_clr", 32'(done), 0);
      check("zero_ready", 32'(cmd_ready), 1);
      $display("txn motor=%0d value=%0d zero-length", m, t);
    end else begin
      sgn = (t > start) ? 1 : -1;
      n   = (t > start) ? t - start : start - t;
      check("setup_busy", 32'(busy), 1);
      check("setup_step", 32'(step), 0);
      check("setup_dir", 32'(dir[m]), (sgn > 0) ? 1 : 0);
      for (int k = 0; k < n * SD; k++) begin
        tick();
        exp_pos = start + sgn * (k / SD);
        check("move_step", 32'(step), ((k % SD) < PW) ? (1 << m) : 0);
        check("move_dir", 32'(dir[m]), (sgn > 0) ? 1 : 0);
        check("move_pos", 32'(pos_out), exp_pos);
        check("move_done", 32'(done), 0);
        if (k == abort_k) begin
          abort = 1'b1;
          tick();
          abort = 1'b0;
          model_pos[m] = exp_pos;
          check("abort_ready", 32'(cmd_ready), 1);
          check("abort_step", 32'(step), 0);
          check("abort_done", 32'(done), 0);
          check("abort_pos", 32'(pos_out), exp_pos);
          $display("txn motor=%0d value=%0d aborted at pos %0d", m, t, exp_pos);
          return;
        end
      end
      tick();
      model_pos[m] = t;
      check("done_pulse", 32'(done), 1);
      check("done_ready", 32'(cmd_ready), 0);
      check("done_pos", 32'(pos_out), t);
      tick();
      check("done_clr", 32'(done), 0);
      check("ret_ready", 32'(cmd_ready), 1);
      $display("txn motor=%0d value=%0d moved %0d steps", m, t, n);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_ready"}, 32'(cmd_ready), 1);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_step"}, 32'(step), 0);
    check({tag, "_dir"}, 32'(dir), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_err"}, 32'(err), 0);
    check_all_pos({tag, "_pos"});
  endtask

  initial begin
    int m, t, ak, n, r;
    for (int i = 0; i < 6; i++) model_pos[i] = 0;
    tick();
    tick();
    check_reset_state("reset");
    rst = 1'b0;
    $display("txn reset");

    run_move(2, 3, -1, 0, 0, 0);
    run_move(2, 1, -1, 0, 0, 0);
    run_move(6, 5, -1, 0, 0, 0);
    run_move(0, 1000, -1, 0, 0, 0);
    run_move(4, 0, -1, 0, 0, 0);
    run_move(1, 10, 13, 0, 0, 0);
    run_move(1, 1, -1, 0, 0, 0);

    // Upper boundary: longest legal move, then a short move back down.
    run_move(0, 999, -1, 0, 0, 0);
    run_move(0, 995, -1, 0, 0, 0);

    // Held command during a busy move is taken only once back in IDLE.
    run_move(3, 2, -1, 1, 0, 990);
    run_move(0, 990, -1, 0, 0, 0);

    // Reset in the middle of a motor 5 move.
    run_move(5, 2, -1, 0, 0, 0);
    cmd_valid = 1'b1;
    cmd_motor = 3'd5;
    cmd_value = 10'd9;
    tick();
    cmd_valid = 1'b0;
    tick();
    check("pre_rst_step", 32'(step), 1 << 5);
    rst = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) model_pos[i] = 0;
    check_reset_state("midrst");
    rst = 1'b0;
    $display("txn reset during motor 5 move");

    for (int i = 0; i < 30; i++) begin
      r = int'($urandom % 10);
      m = (r == 0) ? 6 + int'($urandom % 2) : int'($urandom % 6);
      r = int'($urandom % 10);
      if (r == 0) begin
        t = 1000 + int'($urandom % 24);
      end else if (m < 6) begin
        t = model_pos[m] + int'($urandom_range(0, 16)) - 8;
        if (t < 0) t = 0;
        if (t > 999) t = 999;
      end else begin
        t = int'($urandom % 1000);
      end
      ak = -1;
      if (m < 6 && t <= 999) begin
        n = (t > model_pos[m]) ? t - model_pos[m] : model_pos[m] - t;
        if (n > 0 && ($urandom % 4) == 0) begin
          ak = int'($urandom_range(0, n * SD - 1));
          if ((ak % SD) == SD - 1) ak--;
        end
      end
      run_move(m, t, ak, 0, 0, 0);
    end
    check_all_pos("final_pos");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/motor_driver.md
# motor_driver

Executes committed motor moves. Accepts an absolute target position (0–999) for one of six motors from the operator-input front end. Generates step/direction pulses for that motor until its tracked position matches the target. Sits between the input/commit logic and the six external stepper drivers, and owns the authoritative position register of every motor.

## Interface
Parameters:
- NUM_MOTORS, 6, number of motors, indices 0..NUM_MOTORS-1
- POS_W, 10, position width
- MAX_POS, 999, largest legal target
- STEP_DIV, 1000, clock cycles per step period (≥ PULSE_W+1)
- PULSE_W, 10, cycles step is held high within a period (≥1)

Ports:
- clk  in  1  system clock, all logic rising-edge
- rst  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high when the block can accept; accept = cmd_valid & cmd_ready at a rising edge
- cmd_motor  in  3  motor index
- cmd_value  in  POS_W  absolute target
- abort  in  1  stop current move
- step  out  NUM_MOTORS  step pulses, one bit per motor
- dir  out  NUM_MOTORS  1 = increasing position
- busy  out  1  move in progress
- done  out  1  one-cycle pulse, move completed normally
- err  out  1  one-cycle pulse, command rejected
- pos_sel  in  3  position readback select
- pos_out  out  POS_W  position of motor pos_sel; 0 if pos_sel ≥ NUM_MOTORS

## Operation
- States: IDLE, SETUP, MOVE, DONE. cmd_ready = (state==IDLE); busy = (state==SETUP or MOVE).
- In IDLE, accept latches motor index m and target T.
  - m ≥ NUM_MOTORS or T > MAX_POS: err pulse next cycle, stay IDLE, no state changes.
  - T == pos[m]: go to DONE directly, no steps.
  - Otherwise go to SETUP.
- SETUP (1 cycle): dir[m] = (T > pos[m]); step all 0; period counter cleared.
- MOVE: counter runs 0..STEP_DIV-1. step[m] = (counter < PULSE_W); all other step bits 0. When counter == STEP_DIV-1, pos[m] moves ±1 toward T. If the new value equals T, go to DONE; otherwise the counter wraps to 0.
- DONE (1 cycle): done=1, then IDLE.
- abort is honoured in SETUP or MOVE: next state IDLE, step low the next cycle, pos[m] keeps completed steps only (the partial step is not counted), no done. abort is ignored in IDLE/DONE.
- dir bits of non-active motors hold their last value.
- cmd_valid while not ready is ignored. No queuing; upstream holds it or drops it.
- Positions never leave 0..MAX_POS, because legal targets bound every move.

## Timing
- Reset values: state IDLE, all pos 0, step 0, dir 0, done 0, err 0, busy 0, cmd_ready 1, counter 0.
- rst mid-move: all of the above on the next edge. Step drops immediately with that edge.
- Accept at edge t → SETUP during cycle t+1 → first step high at t+2.
- A move of N steps: done is high during cycle t+2+N·STEP_DIV. cmd_ready returns the following cycle.
- Zero-length move: done during t+1. err during t+1.
- pos_out is combinational from the pos registers. It updates in the same cycle the step period ends.
- dir is stable ≥1 cycle before the first step rising edge and during the whole move.

## Structure
- Shared package motor_pkg: NUM_MOTORS, POS_W, MAX_POS, state enum type, motor index type.
- Sub-module step_timer: period counter with clear/enable. Outputs pulse_hi (counter < PULSE_W) and period_end (counter == STEP_DIV-1). Parameterised by STEP_DIV and PULSE_W.
- Top holds the FSM, the position register array, dir registers, and the readback mux.

## Test plan
Bench parameters: STEP_DIV=4, PULSE_W=2.
- Reset, then command motor 2, value 3:
  - SETUP then 3 periods of step[2] pattern 1100.
  - dir[2]=1.
  - done at cycle t+14.
  - pos_out(sel 2) = 3.
- Then motor 2, value 1: dir[2]=0, 2 pulses, pos 1, other step bits stay 0 throughout.
- Illegal commands, each must give one err pulse, cmd_ready stays high, and leave positions unchanged:
  - motor 6, value 5
  - motor 0, value 1000
- Motor 4, value 0 from pos 0: done at t+1, no step activity.
- Motor 1, value 10, abort asserted at counter 1 of the 4th period: pos 3, no done, cmd_ready the next cycle, new command accepted.
- rst during a motor 5 move at pos 2:
  - step[5] low, pos_out 0 for all selects, IDLE.
  - cmd_valid held during busy is not accepted until IDLE.
